mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/data_memory.sv | 20 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_pkg.sv
// Shared widths, port identifiers and request payload for the two-port memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned N_PORTS   = 2;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter; master = requesters, slave = arbiter.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport mem (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/data_memory.sv
// Single-port word memory with a registered read port; contents are not reset.
module data_memory
  import mem_pkg::*;
(
  input logic         clk,
  mem_arbiter_if.mem  bus
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A write and a read never share a cycle, so read data is always the committed word.
  always_ff @(posedge clk) begin
    if (bus.mem_write) mem_q[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  rdata_q <= mem_q[bus.mem_addr];
  end

  assign bus.mem_rdata = rdata_q;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic: round-robin on last grant, or fixed priority to port 0.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_gnt_i,
  input  logic       mode_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (mode_i || (last_gnt_i == PORT1)) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a shared data memory, with a read-return tracking pipe per port.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic FIXED_PRIO = 1'(PRIORITY_MODE != 0);

  logic [N_PORTS-1:0] req_c;
  logic [N_PORTS-1:0] gnt_c;
  logic               any_gnt_c;
  mem_op_t            op_c;
  logic               rd_c;

  port_id_t           last_gnt_q, last_gnt_d;
  logic               s1_vld_q, s1_vld_d;
  port_id_t           s1_port_q, s1_port_d;
  logic [N_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q [N_PORTS];
  logic [DATA_W-1:0]  rdata_d [N_PORTS];

  // Reset masks requests so no grant or memory strobe escapes during reset.
  assign req_c = {bus.req1, bus.req0} & {N_PORTS{~reset}};

  rr_arbiter2 u_arb (
    .req_i      (req_c),
    .last_gnt_i (last_gnt_q),
    .mode_i     (FIXED_PRIO),
    .gnt_o      (gnt_c)
  );

  assign any_gnt_c = |gnt_c;

  // Winner payload mux; zero when nothing is granted.
  always_comb begin
    op_c = '0;
    if (gnt_c[0]) begin
      op_c.we    = bus.we0;
      op_c.addr  = bus.addr0;
      op_c.wdata = bus.wdata0;
    end else if (gnt_c[1]) begin
      op_c.we    = bus.we1;
      op_c.addr  = bus.addr1;
      op_c.wdata = bus.wdata1;
    end
  end

  assign rd_c          = any_gnt_c & ~op_c.we;
  assign bus.gnt0      = gnt_c[0];
  assign bus.gnt1      = gnt_c[1];
  assign bus.mem_addr  = op_c.addr;
  assign bus.mem_wdata = op_c.wdata;
  assign bus.mem_read  = rd_c;
  assign bus.mem_write = any_gnt_c & op_c.we;

  always_comb begin
    last_gnt_d = last_gnt_q;
    s1_vld_d   = rd_c;
    s1_port_d  = gnt_c[1] ? PORT1 : PORT0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    if (any_gnt_c) last_gnt_d = gnt_c[1] ? PORT1 : PORT0;
    // Memory data for the stage-1 read is valid this cycle; land it on its own port.
    if (s1_vld_q) begin
      rvalid_d[s1_port_q] = 1'b1;
      rdata_d[s1_port_q]  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PORT1;
      s1_vld_q   <= 1'b0;
      s1_port_q  <= PORT0;
      rvalid_q   <= '0;
      rdata_q    <= '{default: '0};
    end else begin
      last_gnt_q <= last_gnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_port_q  <= s1_port_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances driven by the same op lists.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus0 ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.PRIORITY_MODE(0)) u_rr  (.clk(clk), .reset(reset), .bus(bus0));
  mem_arbiter #(.PRIORITY_MODE(1)) u_fix (.clk(clk), .reset(reset), .bus(bus1));
  data_memory u_mem0 (.clk(clk), .bus(bus0));
  data_memory u_mem1 (.clk(clk), .bus(bus1));

  typedef struct packed {
    logic [1:0]  gnt;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  rv;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } obs_t;

  typedef struct packed {
    logic        r0, r1, we0, we1;
    logic [5:0]  a0, a1;
    logic [15:0] d0, d1;
  } in_t;

  typedef struct { bit we; int addr; int wdata; int gap; } op_t;
  typedef struct { int due; int port; int data; } pend_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    rst_cycles = 0;
  op_t   opq [2][2][$];
  bit    presented [2][2];
  pend_t pend [2][$];
  int    m_mem [2][64];
  int    m_rdata [2][2];
  int    m_last [2];
  int    gh [2][$];
  int    rv_count [2];

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  function automatic obs_t get_obs(int d);
    obs_t o;
    if (d == 0) begin
      o.gnt = {bus0.gnt1, bus0.gnt0}; o.rd = bus0.mem_read; o.wr = bus0.mem_write;
      o.addr = bus0.mem_addr; o.wdata = bus0.mem_wdata; o.rv = {bus0.rvalid1, bus0.rvalid0};
      o.rd0 = bus0.rdata0; o.rd1 = bus0.rdata1;
    end else begin
      o.gnt = {bus1.gnt1, bus1.gnt0}; o.rd = bus1.mem_read; o.wr = bus1.mem_write;
      o.addr = bus1.mem_addr; o.wdata = bus1.mem_wdata; o.rv = {bus1.rvalid1, bus1.rvalid0};
      o.rd0 = bus1.rdata0; o.rd1 = bus1.rdata1;
    end
    return o;
  endfunction

  function automatic in_t get_in(int d);
    in_t i;
    if (d == 0) begin
      i.r0 = bus0.req0; i.r1 = bus0.req1; i.we0 = bus0.we0; i.we1 = bus0.we1;
      i.a0 = bus0.addr0; i.a1 = bus0.addr1; i.d0 = bus0.wdata0; i.d1 = bus0.wdata1;
    end else begin
      i.r0 = bus1.req0; i.r1 = bus1.req1; i.we0 = bus1.we0; i.we1 = bus1.we1;
      i.a0 = bus1.addr0; i.a1 = bus1.addr1; i.d0 = bus1.wdata0; i.d1 = bus1.wdata1;
    end
    return i;
  endfunction

  task automatic drive(int d, int p, logic r, logic we, int addr, int wdata);
    if (d == 0 && p == 0) begin
      bus0.req0 = r; bus0.we0 = we; bus0.addr0 = 6'(addr); bus0.wdata0 = 16'(wdata);
    end else if (d == 0) begin
      bus0.req1 = r; bus0.we1 = we; bus0.addr1 = 6'(addr); bus0.wdata1 = 16'(wdata);
    end else if (p == 0) begin
      bus1.req0 = r; bus1.we0 = we; bus1.addr0 = 6'(addr); bus1.wdata0 = 16'(wdata);
    end else begin
      bus1.req1 = r; bus1.we1 = we; bus1.addr1 = 6'(addr); bus1.wdata1 = 16'(wdata);
    end
  endtask

  // Reference model: one step per cycle, evaluated mid-cycle.
  task automatic model_step(int d);
    obs_t       o;
    in_t        in;
    logic [1:0] exp_rv;
    logic [1:0] exp_g;
    pend_t      e;
    int         w;
    logic       e_we;
    int         e_addr, e_data;
    logic       rst;
    rst = reset;
    o   = get_obs(d);
    in  = get_in(d);
    rv_count[d] += int'(o.rv[0]) + int'(o.rv[1]);
    exp_rv = 2'b00;
    while (pend[d].size() > 0 && pend[d][0].due == cyc) begin
      e = pend[d].pop_front();
      exp_rv[e.port] = 1'b1;
      m_rdata[d][e.port] = e.data;
    end
    chk("rvalid", d, 32'(o.rv), 32'(exp_rv));
    chk("rdata0", d, 32'(o.rd0), 32'(m_rdata[d][0]));
    chk("rdata1", d, 32'(o.rd1), 32'(m_rdata[d][1]));

    w = -1;
    if (!rst) begin
      if (in.r0 && in.r1) w = (d == 1 || m_last[d] == 1) ? 0 : 1;
      else if (in.r0)     w = 0;
      else if (in.r1)     w = 1;
    end
    exp_g  = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    e_we   = (w == 0) ? in.we0 : in.we1;
    e_addr = (w < 0) ? 0 : (w == 0) ? int'(in.a0) : int'(in.a1);
    e_data = (w < 0) ? 0 : (w == 0) ? int'(in.d0) : int'(in.d1);
    chk("gnt", d, 32'(o.gnt), 32'(exp_g));
    chk("mem_read", d, 32'(o.rd), 32'((w >= 0) && !e_we));
    chk("mem_write", d, 32'(o.wr), 32'((w >= 0) && e_we));
    chk("mem_addr", d, 32'(o.addr), 32'(e_addr));
    chk("mem_wdata", d, 32'(o.wdata), 32'(e_data));

    if (rst) begin
      pend[d].delete();
      m_rdata[d][0] = 0;
      m_rdata[d][1] = 0;
      m_last[d] = 1;
    end else if (w >= 0) begin
      m_last[d] = w;
      gh[d].push_back(w);
      if (e_we) m_mem[d][e_addr] = e_data;
      else      pend[d].push_back('{due: cyc + 2, port: w, data: m_mem[d][e_addr]});
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1; m_rdata[d][0] = 0; m_rdata[d][1] = 0; rv_count[d] = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      model_step(0);
      model_step(1);
    end
  end

  function automatic bit busy();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (opq[d][p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: present heads just after the edge, retire granted heads mid-cycle.
  task automatic tick();
    obs_t o;
    op_t  h;
    @(posedge clk);
    #1;
    reset = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        if (opq[d][p].size() == 0) begin
          drive(d, p, 1'b0, 1'b0, 0, 0);
          presented[d][p] = 1'b0;
        end else if (opq[d][p][0].gap > 0) begin
          h = opq[d][p][0];
          h.gap--;
          opq[d][p][0] = h;
          drive(d, p, 1'b0, 1'b0, 0, 0);
        end else begin
          h = opq[d][p][0];
          drive(d, p, 1'b1, h.we, h.addr, h.wdata);
          presented[d][p] = 1'b1;
        end
      end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      for (int p = 0; p < 2; p++)
        if (presented[d][p] && o.gnt[p]) begin
          void'(opq[d][p].pop_front());
          presented[d][p] = 1'b0;
        end
    end
  endtask

  task automatic add(int p, bit we, int addr, int wdata, int gap);
    for (int d = 0; d < 2; d++) opq[d][p].push_back('{we: we, addr: addr, wdata: wdata, gap: gap});
  endtask

  task automatic run_phase(string name);
    int n;
    n = 0;
    while (busy() && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 0, 32'(busy()), 32'd0);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) opq[d][p].delete();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic chk_rdata(string name, int exp0, int exp1);
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      chk({name, "_rdata0"}, d, 32'(o.rd0), 32'(exp0));
      chk({name, "_rdata1"}, d, 32'(o.rd1), 32'(exp1));
    end
  endtask

  initial begin
    int rv_base [2];
    int exp_rr [12];
    int exp_fx [12];
    reset = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, 0, 0);
    rst_cycles = 3;
    idle(4);
    chk_rdata("reset", 0, 0);

    // Preload, with port 1 writes contending against port 0 writes.
    add(0, 1, 0, 16'h0001, 0); add(0, 1, 1, 16'h1111, 0); add(0, 1, 2, 16'h2222, 0);
    add(0, 1, 3, 16'h3333, 0); add(0, 1, 4, 16'h4444, 0); add(0, 1, 63, 16'h1234, 0);
    add(1, 1, 6, 16'h6666, 0); add(1, 1, 7, 16'h7777, 0);
    run_phase("preload");
    idle(2);

    // Write then read of the same word in consecutive cycles.
    add(0, 1, 5, 16'hBEEF, 0); add(0, 0, 5, 0, 0);
    run_phase("wr_rd");
    idle(3);
    chk_rdata("wr_rd", 16'hBEEF, 0);

    // Port 1 reads in T, port 0 reads in T+1.
    add(1, 0, 63, 0, 0); add(0, 0, 0, 0, 1);
    run_phase("staggered");
    idle(3);
    chk_rdata("staggered", 16'h0001, 16'h1234);

    add(0, 0, 7, 0, 0); add(1, 0, 6, 0, 0);
    run_phase("cross");
    idle(3);
    chk_rdata("cross", 16'h7777, 16'h6666);

    // Continuous contention from reset; requests already pending while reset is high.
    for (int d = 0; d < 2; d++) gh[d].delete();
    rst_cycles = 2;
    for (int i = 0; i < 6; i++) begin
      add(0, 0, i, 0, 0);
      add(1, 0, (i == 0) ? 63 : i - 1, 0, 0);
    end
    run_phase("contend");
    idle(3);
    for (int i = 0; i < 12; i++) begin
      exp_rr[i] = i % 2;
      exp_fx[i] = (i < 6) ? 0 : 1;
    end
    chk("rr_grant_count", 0, 32'(gh[0].size()), 32'd12);
    chk("fix_grant_count", 1, 32'(gh[1].size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("rr_grant_seq", 0, 32'((i < gh[0].size()) ? gh[0][i] : -1), 32'(exp_rr[i]));
      chk("fix_grant_seq", 1, 32'((i < gh[1].size()) ? gh[1][i] : -1), 32'(exp_fx[i]));
    end
    chk_rdata("contend", 16'hBEEF, 16'h4444);

    // Reset lands the cycle after a read grant: the read must vanish.
    for (int d = 0; d < 2; d++) rv_base[d] = rv_count[d];
    add(0, 0, 3, 0, 0);
    run_phase("rd_reset");
    rst_cycles = 1;
    idle(5);
    for (int d = 0; d < 2; d++) chk("dropped_rvalids", d, 32'(rv_count[d] - rv_base[d]), 32'd0);
    chk_rdata("rd_reset", 0, 0);

    add(0, 0, 5, 0, 0);
    run_phase("post_reset");
    idle(3);
    chk_rdata("post_reset", 16'hBEEF, 0);

    idle(10);
    chk_rdata("quiet", 16'hBEEF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
